fetch_queue_stage: RTL and testbench

- Parametrised successor to the single-instruction fetch stage.
- Issues instruction-memory reads through a request/grant/response handshake and keeps up to MAX_OUT reads in flight.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and hands them to the IF/ID register under valid/ready, so decode can stall without losing fetched instructions.
- A taken branch from EX redirects fetch, flushes the FIFO and discards wrong-path responses still in flight.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue_stage_fifo.sv | 72 +++++++
 rtl/fetch_queue_stage.sv | 184 ++++++++++++++++++
 tb/tb_fetch_queue_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue stage.
// Holds the FIFO entry layout, the NOP encoding that IF/ID inserts on a
// flush, and the default address/instruction widths of the entry type.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int FETCH_ILEN = 32;

    // addi x0, x0, 0 -- bubble inserted by IF/ID when it is flushed
    localparam logic [FETCH_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the PC it was read from
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t.
// Ports: clk, reset (sync, active high), push/wdata, pop/rdata, flush,
//        count (occupancy), empty, full.
// Flush outranks push and pop; push while full and pop while empty are
// ignored so the pointers can never run past each other.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Qualify requests against occupancy
    always_comb begin
        do_push_s = push && (count_r != CW'(DEPTH));
        do_pop_s  = pop && (count_r != CW'(0));
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == CW'(0));
    assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction fetch with up to MAX_OUT reads in flight and
// a DEPTH-entry queue in front of IF/ID.
// Ports: clk, reset (sync, active high); e_b_taken/e_target redirect from EX;
//        mem_i_req/mem_i_ra/mem_i_gnt request side and mem_i_rvalid/mem_i_rd
//        in-order response side of instruction memory; d_valid/d_ready/
//        d_instr/d_pc hand-off to IF/ID (data forced to 0 when not valid).
// fetch_pc names the next address to request; resp_pc names the address the
// next accepted response belongs to. After a redirect, drop_cnt counts the
// wrong-path responses still due and swallows them.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              ILEN     = FETCH_ILEN,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            e_b_taken,
    input  logic [XLEN-1:0] e_target,
    output logic            mem_i_req,
    output logic [XLEN-1:0] mem_i_ra,
    input  logic            mem_i_gnt,
    input  logic            mem_i_rvalid,
    input  logic [ILEN-1:0] mem_i_rd,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [ILEN-1:0] d_instr,
    output logic [XLEN-1:0] d_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] resp_pc_r;
    logic [OW-1:0]   outstanding_r;
    logic [OW-1:0]   drop_cnt_r;

    logic [XLEN-1:0] redirect_pc_s;
    logic [CW:0]     inflight_s;
    logic            req_s;
    logic            grant_s;
    logic            push_s;
    logic            pop_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            unused_target_s;

    assign unused_target_s = ^e_target[1:0];

    // Request/accept decisions; a read is only issued when the queue already
    // has a slot reserved for its response, so pushes never see a full FIFO
    always_comb begin
        redirect_pc_s      = {e_target[XLEN-1:2], 2'b00};
        inflight_s         = (CW+1)'(outstanding_r) + (CW+1)'(fifo_count_s);
        req_s              = !reset && !e_b_taken &&
                             (outstanding_r < OW'(MAX_OUT)) &&
                             (inflight_s < (CW+1)'(DEPTH));
        grant_s            = req_s && mem_i_gnt;
        push_s             = !reset && !e_b_taken && mem_i_rvalid &&
                             (drop_cnt_r == OW'(0));
        pop_s              = !fifo_empty_s && d_ready;
        push_entry_s.pc    = resp_pc_r;
        push_entry_s.instr = mem_i_rd;
    end

    // PC registers and in-flight/drop accounting; redirect dominates and
    // turns every read still in flight (minus this cycle's response) into a drop
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= OW'(0);
            drop_cnt_r    <= OW'(0);
        end else if (e_b_taken) begin
            fetch_pc_r    <= redirect_pc_s;
            resp_pc_r     <= redirect_pc_s;
            outstanding_r <= outstanding_r - OW'(mem_i_rvalid);
            drop_cnt_r    <= outstanding_r - OW'(mem_i_rvalid);
        end else begin
            if (grant_s) begin
                fetch_pc_r <= fetch_pc_r + XLEN'(4);
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + XLEN'(4);
            end
            case ({grant_s, mem_i_rvalid})
                2'b10:   outstanding_r <= outstanding_r + OW'(1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (mem_i_rvalid && (drop_cnt_r != OW'(0))) begin
                drop_cnt_r <= drop_cnt_r - OW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (push_entry_s),
        .pop   (pop_s),
        .flush (e_b_taken),
        .rdata (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    assign mem_i_req = req_s;
    assign mem_i_ra  = fetch_pc_r;
    assign d_valid   = !fifo_empty_s;
    assign d_instr   = d_valid ? head_s.instr : ILEN'(0);
    assign d_pc      = d_valid ? head_s.pc    : XLEN'(0);

    fetch_queue_stage_chk #(
        .XLEN    (XLEN),
        .ILEN    (ILEN),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .outstanding (outstanding_r),
        .drop_cnt    (drop_cnt_r),
        .count       (fifo_count_s),
        .push        (push_s),
        .full        (fifo_full_s),
        .flush       (e_b_taken),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .d_instr     (d_instr),
        .d_pc        (d_pc)
    );

endmodule

// Invariant checker for fetch_queue_stage: in-flight bookkeeping bounds,
// queue bounds, no push into a full queue, and stable data under backpressure.
module fetch_queue_stage_chk #(
    parameter int XLEN    = 32,
    parameter int ILEN    = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input logic                          clk,
    input logic                          reset,
    input logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
    input logic [$clog2(MAX_OUT+1)-1:0]  drop_cnt,
    input logic [$clog2(DEPTH+1)-1:0]    count,
    input logic                          push,
    input logic                          full,
    input logic                          flush,
    input logic                          d_valid,
    input logic                          d_ready,
    input logic [ILEN-1:0]               d_instr,
    input logic [XLEN-1:0]               d_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    a_drop_bound: assert property (@(posedge clk) disable iff (reset)
        (drop_cnt <= outstanding) && (outstanding <= OW'(MAX_OUT)));

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full));

    a_head_stable: assert property (@(posedge clk) disable iff (reset)
        (d_valid && !d_ready && !flush) |=> ($stable(d_instr) && $stable(d_pc)));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: a default instance at RESET_PC=0 and
// a second instance starting near the top of the address space, each backed
// by a 1-cycle in-order memory returning NOP_INSTR+address.
module tb_fetch_queue_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        e_b_taken;
    logic [31:0] e_target;
    logic        mem_i_gnt;
    logic        d_ready;
    logic        mem_stall;

    logic        mem_i_req,    hi_req;
    logic [31:0] mem_i_ra,     hi_ra;
    logic        mem_i_rvalid, hi_rvalid;
    logic [31:0] mem_i_rd,     hi_rd;
    logic        d_valid,      hi_d_valid;
    logic [31:0] d_instr,      hi_d_instr;
    logic [31:0] d_pc,         hi_d_pc;

    int n_checks;
    int n_fail;

    logic [31:0] q_main [$];
    logic [31:0] q_hi   [$];

    fetch_queue_stage u_dut (
        .clk(clk), .reset(reset), .e_b_taken(e_b_taken), .e_target(e_target),
        .mem_i_req(mem_i_req), .mem_i_ra(mem_i_ra), .mem_i_gnt(mem_i_gnt),
        .mem_i_rvalid(mem_i_rvalid), .mem_i_rd(mem_i_rd),
        .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc)
    );

    fetch_queue_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk(clk), .reset(reset), .e_b_taken(e_b_taken), .e_target(e_target),
        .mem_i_req(hi_req), .mem_i_ra(hi_ra), .mem_i_gnt(mem_i_gnt),
        .mem_i_rvalid(hi_rvalid), .mem_i_rd(hi_rd),
        .d_valid(hi_d_valid), .d_ready(d_ready), .d_instr(hi_d_instr), .d_pc(hi_d_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: grants are sampled just before the rising edge and
    // answered in order during the following cycle unless mem_stall holds them.
    initial begin
        mem_i_rvalid = 1'b0; mem_i_rd = 32'h0;
        hi_rvalid    = 1'b0; hi_rd    = 32'h0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                q_main.delete();
                q_hi.delete();
            end else begin
                if (mem_i_req && mem_i_gnt) q_main.push_back(mem_i_ra);
                if (hi_req && mem_i_gnt)    q_hi.push_back(hi_ra);
            end
            @(posedge clk);
            #1;
            if (!reset && !mem_stall && q_main.size() > 0) begin
                mem_i_rvalid = 1'b1; mem_i_rd = q_main[0] + NOP_INSTR; void'(q_main.pop_front());
            end else begin
                mem_i_rvalid = 1'b0; mem_i_rd = 32'h0;
            end
            if (!reset && !mem_stall && q_hi.size() > 0) begin
                hi_rvalid = 1'b1; hi_rd = q_hi[0] + NOP_INSTR; void'(q_hi.pop_front());
            end else begin
                hi_rvalid = 1'b0; hi_rd = 32'h0;
            end
        end
    end

    // Hold reset across two rising edges, release at a falling edge (cycle 0)
    task automatic do_reset(input logic ready);
        reset = 1'b1; e_b_taken = 1'b0; e_target = 32'h0;
        mem_i_gnt = 1'b1; d_ready = ready; mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; e_b_taken = 1'b0; e_target = 32'h0;
        mem_i_gnt = 1'b1; d_ready = 1'b1; mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (mem_i_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_i_req); end
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid: got %b want 0", d_valid); end
        n_checks++; if (d_instr !== 32'h0 || d_pc !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", d_instr, d_pc); end
        n_checks++; if (mem_i_ra !== 32'h0) begin n_fail++; $display("FAIL reset_ra: got %h want 0", mem_i_ra); end
        n_checks++; if (hi_ra !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_ra_hi: got %h want fffffff8", hi_ra); end
        // run a few cycles, then reset mid-operation
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", d_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b0 || mem_i_req !== 1'b0) begin n_fail++; $display("FAIL midrst_state: valid %b req %b want 0 0", d_valid, mem_i_req); end
        n_checks++; if (mem_i_ra !== 32'h0) begin n_fail++; $display("FAIL midrst_ra: got %h want 0", mem_i_ra); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        n_checks++; if (mem_i_req !== 1'b1 || mem_i_ra !== 32'h0) begin n_fail++; $display("FAIL stream_c0: req %b ra %h want 1 0", mem_i_req, mem_i_ra); end
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b want 0", d_valid); end
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b0 || mem_i_ra !== 32'h4) begin n_fail++; $display("FAIL stream_c1: valid %b ra %h want 0 4", d_valid, mem_i_ra); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (d_valid !== 1'b1 || d_pc !== 32'(4*k) || d_instr !== 32'(4*k) + NOP_INSTR) begin
                n_fail++; $display("FAIL stream_seq: valid %b pc %h instr %h want 1 %h %h", d_valid, d_pc, d_instr, 32'(4*k), 32'(4*k) + NOP_INSTR);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int got;
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 4) begin
                n_checks++; if (mem_i_req !== 1'b0) begin n_fail++; $display("FAIL stall_req c%0d: got %b want 0", k, mem_i_req); end
            end
        end
        n_checks++; if (d_valid !== 1'b1 || d_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head: valid %b pc %h want 1 0", d_valid, d_pc); end
        d_ready = 1'b1;
        exp = 32'h0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (d_valid && d_ready) begin
                n_checks++;
                if (d_pc !== exp || d_instr !== exp + NOP_INSTR) begin n_fail++; $display("FAIL stall_drain: pc %h instr %h want %h %h", d_pc, d_instr, exp, exp + NOP_INSTR); end
                exp = exp + 32'd4; got++;
            end
        end
        n_checks++; if (got != 8) begin n_fail++; $display("FAIL stall_drain_count: got %0d want 8", got); end
    endtask

    task automatic test_gnt_hold();
        logic [31:0] exp;
        int got;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        n_checks++; if (mem_i_req !== 1'b1 || mem_i_ra !== 32'h8) begin n_fail++; $display("FAIL gnt_c2: req %b ra %h want 1 8", mem_i_req, mem_i_ra); end
        mem_i_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (mem_i_req !== 1'b1 || mem_i_ra !== 32'h8) begin n_fail++; $display("FAIL gnt_hold: req %b ra %h want 1 8", mem_i_req, mem_i_ra); end
        end
        mem_i_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_i_ra !== 32'hC) begin n_fail++; $display("FAIL gnt_advance: ra %h want c", mem_i_ra); end
        exp = 32'h8; got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (d_valid && d_ready) begin
                n_checks++;
                if (d_pc !== exp || d_instr !== exp + NOP_INSTR) begin n_fail++; $display("FAIL gnt_seq: pc %h instr %h want %h %h", d_pc, d_instr, exp, exp + NOP_INSTR); end
                exp = exp + 32'd4; got++;
            end
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL gnt_seq_count: got %0d want 3", got); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        int got;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        mem_stall = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_i_req !== 1'b1 || mem_i_ra !== 32'h14) begin n_fail++; $display("FAIL redir_req14: req %b ra %h want 1 14", mem_i_req, mem_i_ra); end
        d_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_i_req !== 1'b0) begin n_fail++; $display("FAIL redir_maxout: req %b want 0", mem_i_req); end
        n_checks++; if (d_valid !== 1'b1 || d_pc !== 32'hC) begin n_fail++; $display("FAIL redir_prehead: valid %b pc %h want 1 c", d_valid, d_pc); end
        e_b_taken = 1'b1; e_target = 32'h203;
        @(negedge clk);
        e_b_taken = 1'b0; d_ready = 1'b1; mem_stall = 1'b0;
        #1;
        n_checks++; if (mem_i_ra !== 32'h200 || mem_i_req !== 1'b0) begin n_fail++; $display("FAIL redir_ra: ra %h req %b want 200 0", mem_i_ra, mem_i_req); end
        n_checks++; if (d_valid !== 1'b0 || d_pc !== 32'h0 || d_instr !== 32'h0) begin n_fail++; $display("FAIL redir_flush: valid %b pc %h instr %h want 0 0 0", d_valid, d_pc, d_instr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale: valid %b pc %h want 0", d_valid, d_pc); end
        end
        exp = 32'h200; got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            if (d_valid && d_ready) begin
                n_checks++;
                if (d_pc !== exp || d_instr !== exp + NOP_INSTR) begin n_fail++; $display("FAIL redir_seq: pc %h instr %h want %h %h", d_pc, d_instr, exp, exp + NOP_INSTR); end
                exp = exp + 32'd4; got++;
            end
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL redir_seq_count: got %0d want 3", got); end
    endtask

    task automatic test_redirect_twice();
        logic [31:0] exp;
        int got;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        n_checks++; if (d_valid !== 1'b1 || d_pc !== 32'h0 || mem_i_rvalid !== 1'b1) begin n_fail++; $display("FAIL twice_pre: valid %b pc %h rvalid %b want 1 0 1", d_valid, d_pc, mem_i_rvalid); end
        e_b_taken = 1'b1; e_target = 32'h300;
        @(negedge clk);
        e_b_taken = 1'b0;
        #1;
        n_checks++; if (mem_i_req !== 1'b1 || mem_i_ra !== 32'h300 || d_valid !== 1'b0) begin n_fail++; $display("FAIL twice_first: req %b ra %h valid %b want 1 300 0", mem_i_req, mem_i_ra, d_valid); end
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL twice_gap: valid %b want 0", d_valid); end
        e_b_taken = 1'b1; e_target = 32'h400;
        @(negedge clk);
        e_b_taken = 1'b0;
        #1;
        n_checks++; if (mem_i_ra !== 32'h400 || d_valid !== 1'b0) begin n_fail++; $display("FAIL twice_second: ra %h valid %b want 400 0", mem_i_ra, d_valid); end
        exp = 32'h400; got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            if (d_valid && d_ready) begin
                n_checks++;
                if (d_pc !== exp || d_instr !== exp + NOP_INSTR) begin n_fail++; $display("FAIL twice_seq: pc %h instr %h want %h %h", d_pc, d_instr, exp, exp + NOP_INSTR); end
                exp = exp + 32'd4; got++;
            end
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL twice_seq_count: got %0d want 3", got); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset(1'b1);
        @(negedge clk);
        exp = 32'hFFFF_FFF8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (hi_d_valid !== 1'b1 || hi_d_pc !== exp || hi_d_instr !== exp + NOP_INSTR) begin
                n_fail++; $display("FAIL wrap_seq: valid %b pc %h instr %h want 1 %h %h", hi_d_valid, hi_d_pc, hi_d_instr, exp, exp + NOP_INSTR);
            end
            exp = exp + 32'd4;
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; e_b_taken = 1'b0; e_target = 32'h0;
        mem_i_gnt = 1'b1; d_ready = 1'b1; mem_stall = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_gnt_hold();
        test_redirect();
        test_redirect_twice();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
